fc_argmax: RTL and testbench
============================

# fc_argmax

Classification back-end that consumes the serial class-score stream produced by the fully connected layer and emits the winning class index. Scores arrive one per `valid_in` cycle, indices 0..OUTPUT_NUM-1 in order. The block tracks a running signed maximum and pulses `valid_out` with the decision once the frame completes. The last completed frame's scores are held in a double-buffered bank, readable for debug while the next frame accumulates.

## Interface
- OUTPUT_NUM, 10, scores per frame (class count)
- DATA_WIDTH, 12, score width, two's complement
- IDX_WIDTH, 4, class index width, $clog2(OUTPUT_NUM)
- clk  in  1  clock
- rst_n  in  1  reset: synchronous, active-low; clock clk
- valid_in  in  1  `data_in` holds a valid score this cycle
- data_in  in  DATA_WIDTH  signed score, class index implied by arrival order
- score_rd_idx  in  IDX_WIDTH  debug readback class index
- decision  out  IDX_WIDTH  argmax of last completed frame
- max_score  out  DATA_WIDTH  maximum score of last completed frame
- valid_out  out  1  one-cycle pulse: `decision`/`max_score` just updated
- frame_cnt  out  8  completed frames, wraps 255 -> 0
- score_rd_data  out  DATA_WIDTH  registered readback from the completed bank

## Operation
- Reset values: decision 0, max_score 0, valid_out 0, frame_cnt 0, score_rd_data 0, sample counter 0, state IDLE, bank select 0, all bank entries 0.
- States:
  - IDLE (counter 0).
  - ACCUM (counter 1..OUTPUT_NUM-1).
  - IDLE -> ACCUM on `valid_in`.
  - ACCUM -> IDLE on the `valid_in` carrying sample OUTPUT_NUM-1.
- Sample 0 loads the running max and running index (index 0) unconditionally.
- Sample k>0 replaces the running max only if `data_in` > running max under a signed compare.
- Ties keep the lower index.
- Each accepted sample is written to working-bank entry k.
- On sample OUTPUT_NUM-1:
  - Compute the final compare including that sample.
  - Register `decision` and `max_score`.
  - Pulse `valid_out`.
  - Increment `frame_cnt`.
  - Toggle bank select: the working bank becomes the completed bank.
- `decision`/`max_score` hold until the next frame completes.
- No backpressure; `valid_in` gaps of any length are allowed mid-frame and the counter holds.
- Readback:
  - `score_rd_data` <= completed_bank[`score_rd_idx`] every cycle.
  - `score_rd_idx` >= OUTPUT_NUM returns 0.
  - Before the first completed frame, readback returns 0.
- Reset mid-frame discards the partial frame. The completed bank is cleared, since reset zeroes all entries.

## Timing
- Latency: `valid_out` high in the cycle immediately after the cycle carrying sample OUTPUT_NUM-1. Updated `decision`, `max_score` and `frame_cnt` are visible in that same cycle.
- `valid_out` is exactly one cycle wide and never asserted in consecutive cycles.
- Back-to-back frames:
  - Sample 0 of the next frame is accepted in the same cycle `valid_out` is high.
  - That sample does not disturb the `decision`/`max_score` just registered.
- Bank swap happens at the same edge as the `valid_out` rise. A read issued in that cycle returns the new frame's data one cycle later.
- Readback latency: 1 cycle.
- `rst_n` low has priority over `valid_in` at the same edge.
- `frame_cnt` wraps to 0 after 255 with no flag.

## Structure
- Shared CNN package:
  - CLASS_NUM (=10)
  - FC_DATA_WIDTH (=12)
  - CLASS_IDX_WIDTH (=4)
  - state enum {IDLE, ACCUM}
  - These constants are shared with the fully connected layer.
- One sub-module, `fc_score_bank`, holds:
  - 2 × OUTPUT_NUM × DATA_WIDTH registers
  - write port into the working bank
  - bank-select toggle input
  - registered read port with out-of-range zeroing
- The top holds the counter, FSM, compare and output registers.

## Test plan
- Reset, then scores 5, -3, 100, 7, 0, -50, 99, 1, 2, 3 → `valid_out` one cycle after the 10th; decision 2, max_score 0x064, frame_cnt 1.
- All ten scores 0xFEC (-20) → decision 0, max_score 0xFEC; confirms tie-to-lowest and the signed path.
- Scores 0x800 (-2048) ×9, then 0x7FF → decision 9, max_score 0x7FF; 0x800 never beats 0x7FF.
- Two frames back-to-back, second with random 0–5 cycle `valid_in` gaps, max 0x010 at index 4 → first decision held until the second `valid_out`, then decision 4; `valid_out` pulses only twice.
- Four samples, `rst_n` low one cycle, then a full frame with max at index 7 → single `valid_out`, decision 7, frame_cnt 1.
- After the first-scenario frame:
  - Read idx 3 → 0x007.
  - Read idx 12 → 0.
  - During the next frame's accumulation, idx 2 still reads 0x064 until the swap.

Source files
------------

// File: rtl/fc_argmax_pkg.sv
// Shared CNN constants and FSM state type.
// Constants are common to the fully connected layer and its argmax back-end.
package fc_argmax_pkg;

  localparam int CLASS_NUM       = 10;
  localparam int FC_DATA_WIDTH   = 12;
  localparam int CLASS_IDX_WIDTH = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

endpackage

// File: rtl/fc_score_bank.sv
// Double-buffered score bank: one bank fills while the other is read back.
// Read port is registered and returns 0 for out-of-range indices.
module fc_score_bank #(
  parameter int OUTPUT_NUM = 10,
  parameter int DATA_WIDTH = 12,
  parameter int IDX_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [IDX_WIDTH-1:0]  wr_idx,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  swap,
  input  logic [IDX_WIDTH-1:0]  rd_idx,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam logic [IDX_WIDTH:0] NUM = (IDX_WIDTH+1)'(OUTPUT_NUM);

  logic [DATA_WIDTH-1:0] mem [2][OUTPUT_NUM];
  logic                  sel;
  logic                  wr_ok;
  logic                  rd_ok;

  assign wr_ok = ({1'b0, wr_idx} < NUM);
  assign rd_ok = ({1'b0, rd_idx} < NUM);

  // Working-bank write, bank swap and registered completed-bank read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sel     <= 1'b0;
      rd_data <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int k = 0; k < OUTPUT_NUM; k++) begin
          mem[b][k] <= '0;
        end
      end
    end else begin
      if (wr_en && wr_ok) begin
        mem[sel][wr_idx] <= wr_data;
      end
      if (swap) begin
        sel <= ~sel;
      end
      if (rd_ok) begin
        rd_data <= mem[~sel][rd_idx];
      end else begin
        rd_data <= '0;
      end
    end
  end

endmodule

// File: rtl/fc_argmax.sv
// Argmax over the serial class-score stream of the fully connected layer.
// Emits the winning index and score once per completed frame.
module fc_argmax
  import fc_argmax_pkg::*;
#(
  parameter int OUTPUT_NUM = CLASS_NUM,
  parameter int DATA_WIDTH = FC_DATA_WIDTH,
  parameter int IDX_WIDTH  = CLASS_IDX_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  valid_in,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [IDX_WIDTH-1:0]  score_rd_idx,
  output logic [IDX_WIDTH-1:0]  decision,
  output logic [DATA_WIDTH-1:0] max_score,
  output logic                  valid_out,
  output logic [7:0]            frame_cnt,
  output logic [DATA_WIDTH-1:0] score_rd_data
);

  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(OUTPUT_NUM - 1);

  state_t                state_q;
  state_t                state_d;
  logic [IDX_WIDTH-1:0]  cnt;
  logic [DATA_WIDTH-1:0] run_max;
  logic [IDX_WIDTH-1:0]  run_idx;
  logic                  first;
  logic                  last;
  logic                  take;
  logic [DATA_WIDTH-1:0] cand_max;
  logic [IDX_WIDTH-1:0]  cand_idx;

  assign first = (cnt == '0);
  assign last  = valid_in && (cnt == LAST);

  // Sample 0 seeds the running max; later samples win only if strictly greater.
  always_comb begin
    take     = 1'b0;
    cand_max = run_max;
    cand_idx = run_idx;
    if (first || ($signed(data_in) > $signed(run_max))) begin
      take = 1'b1;
    end
    if (take) begin
      cand_max = data_in;
      cand_idx = cnt;
    end
  end

  // Next state: leave IDLE on any sample, return after the last one.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (valid_in && !last) begin
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (last) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Sample counter and running max; the counter holds across gaps.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt     <= '0;
      run_max <= '0;
      run_idx <= '0;
    end else if (valid_in) begin
      run_max <= cand_max;
      run_idx <= cand_idx;
      if (last) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + IDX_WIDTH'(1);
      end
    end
  end

  // Frame result registers and completion pulse.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      decision  <= '0;
      max_score <= '0;
      valid_out <= 1'b0;
      frame_cnt <= '0;
    end else begin
      valid_out <= last;
      if (last) begin
        decision  <= cand_idx;
        max_score <= cand_max;
        frame_cnt <= frame_cnt + 8'd1;
      end
    end
  end

  fc_score_bank #(
    .OUTPUT_NUM (OUTPUT_NUM),
    .DATA_WIDTH (DATA_WIDTH),
    .IDX_WIDTH  (IDX_WIDTH)
  ) u_bank (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (valid_in),
    .wr_idx  (cnt),
    .wr_data (data_in),
    .swap    (last),
    .rd_idx  (score_rd_idx),
    .rd_data (score_rd_data)
  );

endmodule

// File: tb/tb_fc_argmax.sv
// Scoreboard bench for fc_argmax.
// Stimulus queues expected results; a negedge monitor pops and compares.
module tb_fc_argmax;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        valid_in;
  logic [11:0] data_in;
  logic [3:0]  score_rd_idx;
  logic [3:0]  decision;
  logic [11:0] max_score;
  logic        valid_out;
  logic [7:0]  frame_cnt;
  logic [11:0] score_rd_data;

  typedef struct {
    logic [3:0]  dec;
    logic [11:0] mx;
    logic [7:0]  fc;
  } exp_t;

  exp_t        exp_q[$];
  logic [11:0] rd_q[$];
  logic        rd_req = 1'b0;
  logic        rd_chk = 1'b0;
  logic [7:0]  fc_m;
  logic [3:0]  h_dec;
  logic [11:0] h_max;
  logic [7:0]  h_fc;
  logic        prev_v;
  int          nvec = 0;
  int          nerr = 0;

  fc_argmax dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .valid_in      (valid_in),
    .data_in       (data_in),
    .score_rd_idx  (score_rd_idx),
    .decision      (decision),
    .max_score     (max_score),
    .valid_out     (valid_out),
    .frame_cnt     (frame_cnt),
    .score_rd_data (score_rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, act, exp, $time);
    end
  endtask

  always @(posedge clk) rd_chk <= rd_req;

  // Monitor: frame results, held outputs, pulse width, readback.
  always @(negedge clk) begin
    if (!rst_n) begin
      h_dec  = '0;
      h_max  = '0;
      h_fc   = '0;
      prev_v = 1'b0;
    end else begin
      if (valid_out) begin
        chk("vo_consecutive", {31'd0, prev_v}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("vo_unexpected", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          h_dec = e.dec;
          h_max = e.mx;
          h_fc  = e.fc;
        end
      end
      chk("decision", {28'd0, decision}, {28'd0, h_dec});
      chk("max_score", {20'd0, max_score}, {20'd0, h_max});
      chk("frame_cnt", {24'd0, frame_cnt}, {24'd0, h_fc});
      prev_v = valid_out;
      if (rd_chk) begin
        if (rd_q.size() == 0) begin
          chk("rd_queue_empty", 32'd1, 32'd0);
        end else begin
          chk("score_rd_data", {20'd0, score_rd_data},
              {20'd0, rd_q.pop_front()});
        end
      end
    end
  end

  task automatic cyc(input logic v, input logic [11:0] d,
                     input logic re, input logic [3:0] ri,
                     input logic [11:0] rexp);
    valid_in     = v;
    data_in      = d;
    score_rd_idx = ri;
    rd_req       = re;
    if (re) rd_q.push_back(rexp);
    @(posedge clk);
    #1;
    valid_in = 1'b0;
    rd_req   = 1'b0;
  endtask

  task automatic frame(input logic [11:0] s [10], input logic [3:0] ed,
                       input logic [11:0] em, input bit gaps,
                       input logic re, input logic [3:0] ri,
                       input logic [11:0] rexp);
    for (int i = 0; i < 10; i++) begin
      if (gaps && i > 0) begin
        int g;
        g = $urandom_range(0, 5);
        repeat (g) cyc(1'b0, 12'h000, re, ri, rexp);
      end
      if (i == 9) begin
        exp_t e;
        fc_m++;
        e.dec = ed;
        e.mx  = em;
        e.fc  = fc_m;
        exp_q.push_back(e);
      end
      cyc(1'b1, s[i], re, ri, rexp);
    end
  endtask

  initial begin
    rst_n        = 1'b0;
    valid_in     = 1'b0;
    data_in      = '0;
    score_rd_idx = '0;
    fc_m         = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Readback before any completed frame.
    cyc(1'b0, 12'h000, 1'b1, 4'd2, 12'h000);

    // Mixed signs, max 100 at index 2.
    frame('{12'h005, 12'hFFD, 12'h064, 12'h007, 12'h000,
            12'hFCE, 12'h063, 12'h001, 12'h002, 12'h003},
          4'd2, 12'h064, 1'b0, 1'b0, 4'd0, 12'h000);
    cyc(1'b0, 12'h000, 1'b1, 4'd3, 12'h007);
    cyc(1'b0, 12'h000, 1'b1, 4'd12, 12'h000);

    // All -20: tie keeps index 0; old bank readable until swap.
    frame('{12'hFEC, 12'hFEC, 12'hFEC, 12'hFEC, 12'hFEC,
            12'hFEC, 12'hFEC, 12'hFEC, 12'hFEC, 12'hFEC},
          4'd0, 12'hFEC, 1'b0, 1'b1, 4'd2, 12'h064);
    cyc(1'b0, 12'h000, 1'b1, 4'd2, 12'hFEC);

    // Most negative vs most positive.
    frame('{12'h800, 12'h800, 12'h800, 12'h800, 12'h800,
            12'h800, 12'h800, 12'h800, 12'h800, 12'h7FF},
          4'd9, 12'h7FF, 1'b0, 1'b0, 4'd0, 12'h000);

    // Back-to-back frames, second with gaps and a tie at index 6.
    frame('{12'h003, 12'h001, 12'h004, 12'h001, 12'h005,
            12'h009, 12'h002, 12'h006, 12'h005, 12'h003},
          4'd5, 12'h009, 1'b0, 1'b0, 4'd0, 12'h000);
    frame('{12'h001, 12'h002, 12'h003, 12'hFFC, 12'h010,
            12'h005, 12'h010, 12'h000, 12'hFFF, 12'h00F},
          4'd4, 12'h010, 1'b1, 1'b0, 4'd0, 12'h000);
    cyc(1'b0, 12'h000, 1'b1, 4'd9, 12'h00F);

    // Partial frame, reset with valid_in high, then a clean frame.
    for (int i = 0; i < 4; i++) cyc(1'b1, 12'h7F0, 1'b0, 4'd0, 12'h000);
    rst_n = 1'b0;
    cyc(1'b1, 12'h7FF, 1'b0, 4'd0, 12'h000);
    rst_n = 1'b1;
    fc_m  = '0;
    cyc(1'b0, 12'h000, 1'b1, 4'd9, 12'h000);
    frame('{12'h000, 12'h001, 12'h002, 12'h003, 12'h004,
            12'h005, 12'h006, 12'h032, 12'hFF9, 12'h008},
          4'd7, 12'h032, 1'b0, 1'b0, 4'd0, 12'h000);
    cyc(1'b0, 12'h000, 1'b1, 4'd7, 12'h032);

    repeat (4) cyc(1'b0, 12'h000, 1'b0, 4'd0, 12'h000);
    chk("pending_results", exp_q.size(), 32'd0);
    chk("pending_reads", rd_q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
